// File: rtl/alu_multicycle.sv
// Multicycle ALU: registered single-cycle logic/arithmetic ops plus iterative
// unsigned multiply (shift-add) and divide (restoring) over WIDTH cycles.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] bq;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] simple;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_hi_n;
  logic [WIDTH-1:0] div_lo_n;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last_iter = (cnt == CW'(1));

  always_comb begin
    simple = '0;
    case (alucontrol)
      OP_AND:  simple = a & b;
      OP_OR:   simple = a | b;
      OP_ADD:  simple = a + b;
      OP_SUB:  simple = a - b;
      OP_NOR:  simple = ~(a | b);
      OP_SLT:  simple = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: simple = {{(WIDTH-1){1'b0}}, (a < b)};
      default: simple = '0;
    endcase
  end

  // hi_q:lo_q holds partial product : remaining multiplier bits, shifted right each step
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bq} : '0);
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

  // hi_q is the partial remainder; lo_q shifts dividend bits out and quotient bits in.
  // The remainder stays below bq, so the subtraction fits in WIDTH bits.
  always_comb begin
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, bq});
    div_diff  = div_shift[WIDTH-1:0] - bq;
    div_hi_n  = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_lo_n  = {lo_q[WIDTH-2:0], div_ge};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      bq          <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            bq   <= b;
            lo_q <= a;
            hi_q <= '0;
            cnt  <= CW'(WIDTH);
            if (alucontrol == OP_MULTU) begin
              state <= MUL;
              busy  <= 1'b1;
            end else if ((alucontrol == OP_DIVU) && (b != '0)) begin
              state <= DIV;
              busy  <= 1'b1;
            end else if (alucontrol == OP_DIVU) begin
              result      <= '1;
              result_hi   <= a;
              zero        <= 1'b0;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              result      <= simple;
              result_hi   <= '0;
              zero        <= (simple == '0);
              div_by_zero <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          hi_q <= mul_hi_n;
          lo_q <= mul_lo_n;
          cnt  <= cnt - CW'(1);
          if (last_iter) begin
            result      <= mul_lo_n;
            result_hi   <= mul_hi_n;
            zero        <= (mul_lo_n == '0);
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end
        end
        DIV: begin
          hi_q <= div_hi_n;
          lo_q <= div_lo_n;
          cnt  <= cnt - CW'(1);
          if (last_iter) begin
            result      <= div_lo_n;
            result_hi   <= div_hi_n;
            zero        <= (div_lo_n == '0);
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WIDTH=32 and WIDTH=8.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;

  logic        start32;
  logic [3:0]  op32;
  logic [31:0] a32, b32;
  logic        busy32, done32, zero32, dbz32;
  logic [31:0] res32, hi32;

  logic        start8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, zero8, dbz8;
  logic [7:0]  res8, hi8;

  int checks = 0;
  int errors = 0;
  int lat;
  int nbusy;
  int seen_done;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .alucontrol(op32),
    .a(a32), .b(b32), .busy(busy32), .done(done32), .result(res32),
    .result_hi(hi32), .zero(zero32), .div_by_zero(dbz32)
  );

  alu_multicycle #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .alucontrol(op8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .result(res8),
    .result_hi(hi8), .zero(zero8), .div_by_zero(dbz8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the 32-bit DUT; while busy, spurious starts with junk operands are driven.
  task automatic run32(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       output int latency, output int busy_cycles);
    op32 = op; a32 = x; b32 = y; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    latency = 1;
    busy_cycles = 0;
    while (!done32 && latency < 100) begin
      if (busy32) begin
        busy_cycles++;
        start32 = latency[0];
        op32 = 4'b0010;
        a32 = $urandom;
        b32 = $urandom;
      end else begin
        start32 = 1'b0;
      end
      tick();
      latency++;
    end
    start32 = 1'b0;
  endtask

  task automatic run8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                      output int latency);
    op8 = op; a8 = x; b8 = y; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    latency = 1;
    while (!done8 && latency < 100) begin
      tick();
      latency++;
    end
  endtask

  initial begin
    reset = 1'b1;
    start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    tick();
    tick();
    check("rst_busy", busy32, 0);
    check("rst_done", done32, 0);
    check("rst_res", res32, 0);
    check("rst_hi", hi32, 0);
    check("rst_zero", zero32, 0);
    check("rst_dbz", dbz32, 0);
    reset = 1'b0;
    tick();

    run32(4'b0010, 32'h7FFF_FFFF, 32'h1, lat, nbusy);
    check("add_lat", lat, 1);
    check("add_res", res32, 64'h8000_0000);
    check("add_zero", zero32, 0);
    check("add_hi", hi32, 0);
    op32 = 4'b0110; a32 = 32'd5; b32 = 32'd5; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    check("sub_done", done32, 1);
    check("sub_res", res32, 0);
    check("sub_zero", zero32, 1);
    tick();
    check("sub_done_pulse", done32, 0);
    check("sub_hold", res32, 0);

    run32(4'b0111, 32'hFFFF_FFFF, 32'h1, lat, nbusy);
    check("slt_res", res32, 1);
    run32(4'b0011, 32'hFFFF_FFFF, 32'h1, lat, nbusy);
    check("sltu_res", res32, 0);
    check("sltu_zero", zero32, 1);
    run32(4'b0100, 32'h0, 32'h0, lat, nbusy);
    check("nor_res", res32, 64'hFFFF_FFFF);
    run32(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, lat, nbusy);
    check("and_res", res32, 64'h00F0_1200);
    run32(4'b0001, 32'hF000_0001, 32'h0000_0F00, lat, nbusy);
    check("or_res", res32, 64'hF000_0F01);

    run32(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nbusy);
    check("mul_lat", lat, 33);
    check("mul_busy_cycles", nbusy, 32);
    check("mul_lo", res32, 64'h0000_0001);
    check("mul_hi", hi32, 64'hFFFF_FFFE);
    check("mul_busy_end", busy32, 0);
    tick();
    check("mul_no_queue", done32, 0);
    check("mul_hold_hi", hi32, 64'hFFFF_FFFE);

    run32(4'b1001, 32'd100, 32'd7, lat, nbusy);
    check("div_lat", lat, 33);
    check("div_q", res32, 14);
    check("div_r", hi32, 2);
    check("div_dbz", dbz32, 0);
    run32(4'b1001, 32'h1234_5678, 32'h0, lat, nbusy);
    check("dbz_lat", lat, 1);
    check("dbz_res", res32, 64'hFFFF_FFFF);
    check("dbz_hi", hi32, 64'h1234_5678);
    check("dbz_flag", dbz32, 1);
    check("dbz_zero", zero32, 0);

    op32 = 4'b1000; a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    repeat (4) tick();
    check("abort_busy_pre", busy32, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", busy32, 0);
    check("abort_done", done32, 0);
    check("abort_res", res32, 0);
    check("abort_hi", hi32, 0);
    check("abort_zero", zero32, 0);
    check("abort_dbz", dbz32, 0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done32 || busy32) seen_done++;
      tick();
    end
    check("abort_quiet", seen_done, 0);

    run8(4'b1000, 8'hFF, 8'hFF, lat);
    check("w8_mul_lat", lat, 9);
    check("w8_mul_lo", res8, 8'h01);
    check("w8_mul_hi", hi8, 8'hFE);
    run8(4'b1001, 8'd200, 8'd9, lat);
    check("w8_div_lat", lat, 9);
    check("w8_div_q", res8, 22);
    check("w8_div_r", hi8, 2);
    run8(4'b1111, 8'h5A, 8'h33, lat);
    check("w8_undef_lat", lat, 1);
    check("w8_undef_res", res8, 0);
    check("w8_undef_zero", zero8, 1);
    check("w8_undef_hi", hi8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Registered logic/arithmetic ops complete in 1 cycle. Unsigned multiply and divide run iteratively over WIDTH cycles.
- Uses a start/busy/done handshake, so the controller FSM can stall the multicycle MIPS datapath on MULTU/DIVU.
- Produces a 2×WIDTH result: lo word in result; hi word / remainder in result_hi.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4). Also sets the iteration count for MULTU/DIVU.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- alucontrol  in  4  operation select, sampled with start.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- busy  out  1  high while an iterative op is in progress.
- done  out  1  one-cycle pulse: result, result_hi, zero and div_by_zero are valid.
- result  out  WIDTH  low word / quotient / simple-op result.
- result_hi  out  WIDTH  MULTU high word / DIVU remainder; 0 for simple ops.
- zero  out  1  registered (result == 0).
- div_by_zero  out  1  set with done for DIVU with b=0; else 0.

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- On reset:
  - state → IDLE.
  - busy, done, zero, div_by_zero, result and result_hi all → 0.
  - Reset mid-operation abandons the operation; no done pulse.
- alucontrol encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0100 NOR.
  - 0111 SLT (signed), 0011 SLTU (unsigned).
  - 1000 MULTU, 1001 DIVU.
  - Any other code behaves as a simple op producing result=0.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT/SLTU return 1 or 0 in bit 0, upper bits 0.
- States: IDLE, MUL, DIV, DONE. busy=1 only in MUL and DIV.
- Accept (start=1 & busy=0, in IDLE or DONE):
  - latch a, b and op.
  - Simple op or DIVU-by-zero → DONE next cycle (latency 1).
  - MULTU → MUL; DIVU with b≠0 → DIV. Iteration counter loads WIDTH.
- MUL: shift-add, one multiplier bit per cycle. Exactly WIDTH cycles in MUL, then DONE.
  - done asserts WIDTH+1 cycles after the accept edge.
- DIV: restoring division, one quotient bit per cycle. Same WIDTH-cycle timing as MUL.
- DONE:
  - done=1 for exactly one cycle, with outputs updated on that same edge.
  - Next state is IDLE, unless start=1, which is accepted as a back-to-back op.
- Output hold: result, result_hi, zero and div_by_zero hold their values after done until the next completing op. Intermediate iteration values are never visible on the outputs.
- Operand stability: a, b and alucontrol changes while busy are ignored. start while busy=1 is ignored (not queued).
- Divide by zero: result = all ones, result_hi = a, div_by_zero = 1, latency 1.
- MULTU: {result_hi, result} = full 2×WIDTH unsigned product.
- zero reflects result only, never result_hi.

Test Plan:
- Reset / mid-op abort: assert reset during MUL iteration 5 → next cycle busy=0, done=0, all outputs 0. No done pulse follows.
- Simple ops, 1-cycle latency, back-to-back:
  - ADD 0x7FFFFFFF+1 → result 0x80000000, zero=0.
  - Then SUB 5-5 in the done cycle → result 0, zero=1 one cycle later.
- Signed vs unsigned compare, a=0xFFFFFFFF, b=1:
  - SLT → result 1.
  - SLTU → result 0.
  - NOR 0,0 → result 0xFFFFFFFF.
- MULTU 0xFFFFFFFF×0xFFFFFFFF:
  - busy high 32 cycles; done on cycle 33.
  - result_hi=0xFFFFFFFE, result=0x00000001.
  - start pulses during busy are ignored.
- DIVU:
  - 100/7 → result=14, result_hi=2, div_by_zero=0, done at cycle 33.
  - 0x12345678/0 → done at cycle 1, result=0xFFFFFFFF, result_hi=0x12345678, div_by_zero=1.
- Parametrisation: WIDTH=8, MULTU 0xFF×0xFF → {0xFE,0x01}, done at cycle 9. Undefined code 1111 → result=0, zero=1.
